exp_seq_unit: RTL

Sequential, parametrised exponential engine for the approximate-softmax datapath. It computes e^x by range reduction: x is split into an integer part and NFSEG fractional segments, each segment indexes a small table of e^segment values, and the per-segment factors are multiplied together. Unlike the purely combinational exp stage, this block reuses one MW×MW multiplier across NFSEG cycles, renormalises after every product, flags input saturation, and exposes valid/ready handshakes so the softmax accumulator can stall it.

---
 rtl/exp_seq_unit.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/exp_seq_unit.sv
// exp_seq_unit: sequential e^x engine. Range reduction into an integer part and
// NFSEG fractional segments, multiplied together on one shared MWxMW multiplier.
module exp_seq_unit #(
    parameter int XW    = 17,
    parameter int FW    = 12,
    parameter int SEGW  = 4,
    parameter int NFSEG = 3,
    parameter int MW    = 16,
    parameter int EW    = 6,
    parameter int XLIM  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_mant,
    output logic [EW-1:0] out_exp,
    output logic          out_sat
);

    localparam int NINT = 2 * XLIM + 1;
    localparam int IW   = $clog2(NINT);
    localparam int NSEG = 1 << SEGW;
    localparam int KW   = (NFSEG > 1) ? $clog2(NFSEG) : 1;
    localparam logic signed [XW-1:0] XMAX = XW'(XLIM * (1 << FW));
    localparam logic signed [XW-1:0] XMIN = -XMAX;

    // Normalise a positive real to {exp, mant} with mant in [2^(MW-1), 2^MW).
    function automatic logic [EW+MW-1:0] encode(input real y);
        real m;
        real sc;
        int  e;
        int  q;
        m  = y;
        e  = 0;
        sc = 1.0;
        for (int i = 0; i < 128; i++) begin
            if (m >= 2.0) begin
                m = m / 2.0;
                e++;
            end else if (m < 1.0) begin
                m = m * 2.0;
                e--;
            end
        end
        for (int i = 0; i < MW - 1; i++) sc = sc * 2.0;
        q = $rtoi(m * sc + 0.5);
        if (q >= (1 << MW)) begin
            q = 1 << (MW - 1);
            e++;
        end
        return {EW'(e), MW'(q)};
    endfunction

    function automatic logic [EW+MW-1:0] seg_entry(input int k, input int f);
        real v;
        v = real'(f);
        for (int i = 0; i < SEGW * (k + 1); i++) v = v / 2.0;
        return encode($exp(v));
    endfunction

    logic [EW+MW-1:0] int_tab [NINT];
    logic [EW+MW-1:0] seg_tab [NFSEG*NSEG];

    for (genvar i = 0; i < NINT; i++) begin : g_int
        assign int_tab[i] = encode($exp(real'(i - XLIM)));
    end
    for (genvar k = 0; k < NFSEG; k++) begin : g_seg_k
        for (genvar f = 0; f < NSEG; f++) begin : g_seg_f
            assign seg_tab[k*NSEG+f] = seg_entry(k, f);
        end
    end

    typedef enum logic [1:0] {IDLE, INT, MUL, DONE} state_t;

    state_t                state;
    logic signed [XW-1:0]  xc;
    logic                  sat;
    logic [FW-1:0]         frac;
    logic [KW-1:0]         seg;
    logic [MW-1:0]         acc_mant;
    logic [EW-1:0]         acc_exp;

    logic signed [XW-1:0]  x_s;
    logic signed [XW-1:0]  xc_next;
    logic                  clamp;
    logic [IW-1:0]         int_idx;
    logic [SEGW-1:0]       field;
    logic [MW-1:0]         m_k;
    logic [EW-1:0]         e_k;
    logic [2*MW-1:0]       prod;
    logic [MW-1:0]         hi;
    logic                  rbit;
    logic                  bump;
    logic [MW:0]           rnd;
    logic                  ovf;
    logic [MW-1:0]         mant_nx;
    logic [EW-1:0]         exp_nx;
    logic                  unused_lsbs;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);

    assign x_s     = $signed(x);
    assign clamp   = (x_s > XMAX) || (x_s < XMIN);
    assign xc_next = (x_s > XMAX) ? XMAX : ((x_s < XMIN) ? XMIN : x_s);

    // Arithmetic floor of xc: the integer field is already two's complement.
    assign int_idx = IW'($signed(xc[XW-1:FW]) + XLIM);

    assign field        = frac[FW-1 -: SEGW];
    assign {e_k, m_k}   = seg_tab[{seg, field}];
    assign prod         = {{MW{1'b0}}, acc_mant} * {{MW{1'b0}}, m_k};
    assign unused_lsbs  = ^prod[MW-3:0];

    always_comb begin
        hi   = '0;
        rbit = 1'b0;
        bump = 1'b0;
        if (prod[2*MW-1]) begin
            hi   = prod[2*MW-1:MW];
            rbit = prod[MW-1];
            bump = 1'b1;
        end else begin
            hi   = prod[2*MW-2:MW-1];
            rbit = prod[MW-2];
        end
        rnd     = {1'b0, hi} + {{MW{1'b0}}, rbit};
        ovf     = rnd[MW];
        mant_nx = ovf ? {1'b1, {(MW-1){1'b0}}} : rnd[MW-1:0];
        exp_nx  = acc_exp + e_k + {{(EW-1){1'b0}}, bump} + {{(EW-1){1'b0}}, ovf};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            xc        <= '0;
            sat       <= 1'b0;
            frac      <= '0;
            seg       <= '0;
            acc_mant  <= '0;
            acc_exp   <= '0;
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xc    <= xc_next;
                        sat   <= clamp;
                        state <= INT;
                    end
                end
                INT: begin
                    {acc_exp, acc_mant} <= int_tab[int_idx];
                    frac  <= xc[FW-1:0];
                    seg   <= '0;
                    state <= MUL;
                end
                MUL: begin
                    acc_mant <= mant_nx;
                    acc_exp  <= exp_nx;
                    frac     <= frac << SEGW;
                    seg      <= seg + 1'b1;
                    if (seg == KW'(NFSEG - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_mant  <= mant_nx;
                        out_exp   <= exp_nx;
                        out_sat   <= sat;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            xc    <= xc_next;
                            sat   <= clamp;
                            state <= INT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
